reg_dump_unit: RTL and testbench

REG_DUMP_UNIT -- requirements
Module: reg_dump_unit

---
 rtl/reg_dump_unit_pkg.sv | 26 ++
 rtl/reg_dump_unit_if.sv | 25 ++
 rtl/reg_dump_unit.sv | 127 ++++++++++++
 tb/tb_reg_dump_unit.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/reg_dump_unit_pkg.sv
// Shared constants and FSM encoding for the register dump unit.
// REG_DUMP_CHECKSUM_EN adds a trailing XOR checksum byte (CSUM state).
package reg_dump_unit_pkg;

   localparam int NUM_REGS = 8;
   localparam int ADDR_W   = 3;
   localparam int DATA_W   = 8;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

`ifdef REG_DUMP_CHECKSUM_EN
   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SEND,
      CSUM
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      SEND
   } state_t;
`endif

endpackage

// File: rtl/reg_dump_unit_if.sv
// Byte stream carrying the dump out of reg_dump_unit.
// valid/ready handshake with a last marker on the final byte.
interface reg_dump_unit_if;
   import reg_dump_unit_pkg::*;

   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   modport master (
      output out_data,
      output out_valid,
      output out_last,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      input  out_last,
      output out_ready
   );

endinterface

// File: rtl/reg_dump_unit.sv
// Walks register-file B port over regs 0..7 and streams each byte out.
// REG_DUMP_CHECKSUM_EN appends the XOR of the eight bytes as a 9th byte.
module reg_dump_unit
   import reg_dump_unit_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [ADDR_W-1:0] rf_addr,
   output logic              rf_mb_select,
   input  logic [DATA_W-1:0] rf_data,
   reg_dump_unit_if.master   dump,
   output logic              busy,
   output logic              done
);

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] data_q;
   logic              valid_q;
   logic              done_q;
   logic              xfer;
   logic              at_last;
`ifdef REG_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] csum;
`endif

   assign xfer    = valid_q & dump.out_ready;
   assign at_last = (idx == LAST_IDX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (start) state_nx = FETCH;
         FETCH: state_nx = SEND;
         SEND: begin
            if (xfer) begin
               if (!at_last) state_nx = FETCH;
`ifdef REG_DUMP_CHECKSUM_EN
               else          state_nx = CSUM;
`else
               else          state_nx = IDLE;
`endif
            end
         end
`ifdef REG_DUMP_CHECKSUM_EN
         CSUM:  if (xfer) state_nx = IDLE;
`endif
         default: state_nx = IDLE;
      endcase
   end

   // idx stops at the last register; it is only cleared by the next start
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx     <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
         csum    <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  idx  <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
                  csum <= '0;
`endif
               end
            end
            FETCH: begin
               data_q  <= rf_data;
               valid_q <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
               csum    <= csum ^ rf_data;
`endif
            end
            SEND: begin
               if (xfer) begin
                  if (!at_last) begin
                     idx     <= idx + ADDR_W'(1);
                     valid_q <= 1'b0;
                  end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                     data_q  <= csum;
`else
                     valid_q <= 1'b0;
                     done_q  <= 1'b1;
`endif
                  end
               end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
               if (xfer) begin
                  valid_q <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign rf_addr        = idx;
   assign rf_mb_select   = 1'b0;
   assign dump.out_data  = data_q;
   assign dump.out_valid = valid_q;
`ifdef REG_DUMP_CHECKSUM_EN
   assign dump.out_last  = valid_q & (state == CSUM);
`else
   assign dump.out_last  = valid_q & (state == SEND) & at_last;
`endif
   assign busy           = (state != IDLE);
   assign done           = done_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit: vector table plus reset,
// busy-start and back-to-back sequences.
module tb_reg_dump_unit;
   import reg_dump_unit_pkg::*;

`ifdef REG_DUMP_CHECKSUM_EN
   localparam int NB  = 9;
   localparam int CYC = 18;
`else
   localparam int NB  = 8;
   localparam int CYC = 17;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [2:0] rf_addr;
   logic       rf_mb_select;
   logic [7:0] rf_data;
   logic       busy;
   logic       done;
   logic [7:0] rf [8];

   reg_dump_unit_if dif ();

   assign rf_data = rf_mb_select ? {5'b0, rf_addr} : rf[rf_addr];

   reg_dump_unit dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .rf_addr      (rf_addr),
      .rf_mb_select (rf_mb_select),
      .rf_data      (rf_data),
      .dump         (dif.master),
      .busy         (busy),
      .done         (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0][7:0] d;
      bit              toggle;
      bit              restart3;
      logic [7:0]      csum;
      int              cyc;
   } vec_t;

   vec_t       vecs [4];
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] got [$];
   bit         lasts [$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic load(input logic [7:0][7:0] d);
      for (int i = 0; i < 8; i++) rf[i] = d[i];
   endtask

   task automatic run_dump(input bit toggle, input bit restart3,
                           output int ncyc, output int ndone);
      bit         stalled = 1'b0;
      bit         phase   = 1'b0;
      bit         rdy;
      logic [7:0] hd = '0;
      got.delete();
      lasts.delete();
      ncyc  = 0;
      ndone = 0;
      @(negedge clk);
      start         = 1'b1;
      dif.out_ready = 1'b1;
      for (int c = 1; c < 400; c++) begin
         @(negedge clk);
         start = 1'b0;
         rdy   = toggle ? phase : 1'b1;
         phase = ~phase;
         dif.out_ready = rdy;
         if (stalled) begin
            chk("stall_valid", {31'b0, dif.out_valid}, 32'd1);
            chk("stall_data", {24'b0, dif.out_data}, {24'b0, hd});
         end
         if (dif.out_valid) begin
            if (rdy) begin
               got.push_back(dif.out_data);
               lasts.push_back(dif.out_last);
               stalled = 1'b0;
               if (restart3 && got.size() == 4) start = 1'b1;
            end else begin
               stalled = 1'b1;
               hd      = dif.out_data;
            end
         end else begin
            stalled = 1'b0;
         end
         if (done) begin
            ndone++;
            if (ndone == 1) begin
               ncyc = c;
               chk("done_busy", {31'b0, busy}, 32'd0);
            end
         end
         if (ndone > 0 && c >= ncyc + 4) break;
      end
      chk("idle_after", {31'b0, busy}, 32'd0);
   endtask

   task automatic check_bytes(input vec_t v, input int off);
      logic [7:0] e;
      chk("byte_count", got.size(), off + NB);
      for (int i = 0; i < NB && off + i < got.size(); i++) begin
         e = (i < 8) ? v.d[i] : v.csum;
         chk($sformatf("byte%0d", i), {24'b0, got[off + i]}, {24'b0, e});
         chk($sformatf("last%0d", i), {31'b0, lasts[off + i]},
             (i == NB - 1) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      int ncyc, ndone, nd, idle_cnt, found, stop_at;

      vecs[0] = '{d: 64'h1716151413121110, toggle: 0, restart3: 0,
                  csum: 8'h00, cyc: CYC};
      vecs[1] = '{d: 64'h1716151413121110, toggle: 1, restart3: 0,
                  csum: 8'h00, cyc: 0};
      vecs[2] = '{d: 64'h8040201008040201, toggle: 0, restart3: 1,
                  csum: 8'hFF, cyc: CYC};
      vecs[3] = '{d: 64'h7F81C33C00FF5AA5, toggle: 1, restart3: 1,
                  csum: 8'h01, cyc: 0};

      reset         = 1'b1;
      start         = 1'b0;
      dif.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) rf[i] = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_valid", {31'b0, dif.out_valid}, 32'd0);
      chk("rst_last", {31'b0, dif.out_last}, 32'd0);
      chk("rst_data", {24'b0, dif.out_data}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_addr", {29'b0, rf_addr}, 32'd0);
      chk("mb_select", {31'b0, rf_mb_select}, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 4; k++) begin
         load(vecs[k].d);
         run_dump(vecs[k].toggle, vecs[k].restart3, ncyc, ndone);
         chk($sformatf("v%0d_done_count", k), ndone, 32'd1);
         if (vecs[k].cyc != 0)
            chk($sformatf("v%0d_cycles", k), ncyc, vecs[k].cyc);
         check_bytes(vecs[k], 0);
      end

      // reset while the unit is stalled on register 5
      load(vecs[0].d);
      @(negedge clk);
      start         = 1'b1;
      dif.out_ready = 1'b0;
      found         = 0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (dif.out_valid && rf_addr == 3'd5) begin
            dif.out_ready = 1'b0;
            found = 1;
            break;
         end
         dif.out_ready = dif.out_valid;
      end
      chk("mid_reached_idx5", found, 32'd1);
      #1 reset = 1'b1;
      #1;
      chk("mid_rst_valid", {31'b0, dif.out_valid}, 32'd0);
      chk("mid_rst_busy", {31'b0, busy}, 32'd0);
      chk("mid_rst_last", {31'b0, dif.out_last}, 32'd0);
      chk("mid_rst_addr", {29'b0, rf_addr}, 32'd0);
      chk("mid_rst_data", {24'b0, dif.out_data}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      run_dump(1'b0, 1'b0, ncyc, ndone);
      chk("restart_done_count", ndone, 32'd1);
      check_bytes(vecs[0], 0);

      // start held high: two dumps, one idle cycle apart
      load(vecs[2].d);
      got.delete();
      lasts.delete();
      @(negedge clk);
      start         = 1'b1;
      dif.out_ready = 1'b1;
      nd            = 0;
      idle_cnt      = 0;
      stop_at       = 0;
      for (int c = 1; c < 200; c++) begin
         @(negedge clk);
         if (dif.out_valid) begin
            got.push_back(dif.out_data);
            lasts.push_back(dif.out_last);
         end
         if (done) begin
            nd++;
            if (nd == 2) begin
               start   = 1'b0;
               stop_at = c + 4;
            end
         end
         if (nd == 1 && !busy) idle_cnt++;
         if (stop_at != 0 && c >= stop_at) break;
      end
      start = 1'b0;
      chk("b2b_done_count", nd, 32'd2);
      chk("b2b_idle_cycles", idle_cnt, 32'd1);
      chk("b2b_final_busy", {31'b0, busy}, 32'd0);
      check_bytes(vecs[2], NB);
      if (got.size() >= NB) begin
         chk("b2b_first0", {24'b0, got[0]}, 32'h01);
         chk("b2b_first_last", {31'b0, lasts[NB - 1]}, 32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
